// File: rtl/lab5_fetch_unit_pkg.sv
// Shared definitions for the lab5 fetch stage: FSM encoding, instruction field
// positions and the halt word.
package lab5_fetch_unit_pkg;

   typedef enum logic [1:0] {
      StInit = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } state_e;

   localparam int unsigned INSTR_W    = 16;
   localparam int unsigned OPCODE_MSB = 15;
   localparam int unsigned OPCODE_LSB = 12;
   localparam int unsigned RS_MSB     = 11;
   localparam int unsigned RS_LSB     = 9;
   localparam int unsigned RT_MSB     = 8;
   localparam int unsigned RT_LSB     = 6;
   localparam int unsigned IMM6_MSB   = 5;
   localparam int unsigned IMM6_LSB   = 0;
   localparam int unsigned FUNCT_MSB  = 2;
   localparam int unsigned FUNCT_LSB  = 0;

   localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

   function automatic logic is_halt_word(input logic [INSTR_W-1:0] word);
      return word == HALT_WORD;
   endfunction

endpackage

// File: rtl/lab5_fetch_unit_next_pc.sv
// Combinational next-PC selection: stall/halt hold, jump, branch, sequential.
// All sums wrap modulo 2^PC_W.
module lab5_fetch_unit_next_pc #(
   parameter int unsigned PC_W = 8
) (
   input  logic [PC_W-1:0] pc,
   input  logic            stall,
   input  logic            halt_zero,
   input  logic            jmp_en,
   input  logic [PC_W-1:0] jmp_addr,
   input  logic            br_taken,
   input  logic [5:0]      br_offset,
   output logic [PC_W-1:0] next_pc
);

   logic [PC_W-1:0] pc_seq;
   logic [PC_W-1:0] br_delta;
   logic            unused_jmp_lsb;

   assign pc_seq = pc + PC_W'(2);

   // Word offset to byte offset, sign-extended to the PC width.
   assign br_delta = PC_W'({{PC_W{br_offset[5]}}, br_offset, 1'b0});

   // Targets are always halfword aligned.
   assign unused_jmp_lsb = jmp_addr[0];

   always_comb begin
      next_pc = pc_seq;
      if (stall || halt_zero) begin
         next_pc = pc;
      end else if (jmp_en) begin
         next_pc = {jmp_addr[PC_W-1:1], 1'b0};
      end else if (br_taken) begin
         next_pc = pc_seq + br_delta;
      end
   end

endmodule

// File: rtl/lab5_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction RAM address,
// forwards the fetched word to decode, detects halt and counts retirements.
module lab5_fetch_unit
   import lab5_fetch_unit_pkg::*;
#(
   parameter int unsigned     PC_W         = 8,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter bit              HALT_ON_ZERO = 1'b1,
   parameter int unsigned     CNT_W        = 16
) (
   input  logic               CLK,
   input  logic               RESET,
   output logic [PC_W-1:0]    IADDR,
   input  logic [INSTR_W-1:0] IRAM_Q,
   output logic [INSTR_W-1:0] INSTR,
   output logic               INSTR_VALID,
   input  logic               STALL,
   input  logic               BR_TAKEN,
   input  logic [5:0]         BR_OFFSET,
   input  logic               JMP_EN,
   input  logic [PC_W-1:0]    JMP_ADDR,
   output logic               HALTED,
   output logic [CNT_W-1:0]   RETIRED
);

   state_e           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [PC_W-1:0]  next_pc;
   logic             run;
   logic             zero_instr;
   logic             retire;

   assign run        = (state_q == StRun);
   assign zero_instr = HALT_ON_ZERO && is_halt_word(IRAM_Q);
   assign retire     = run && INSTR_VALID && !STALL;

   assign IADDR       = pc_q;
   assign INSTR       = run ? IRAM_Q : HALT_WORD;
   assign INSTR_VALID = run && !zero_instr;
   assign HALTED      = (state_q == StHalt);
   assign RETIRED     = retired_q;

   lab5_fetch_unit_next_pc #(
      .PC_W (PC_W)
   ) u_next_pc (
      .pc        (pc_q),
      .stall     (STALL),
      .halt_zero (zero_instr),
      .jmp_en    (JMP_EN),
      .jmp_addr  (JMP_ADDR),
      .br_taken  (BR_TAKEN),
      .br_offset (BR_OFFSET),
      .next_pc   (next_pc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StInit: state_d = StRun;
         StRun: begin
            // A stalled zero word is not yet final; decide when it is presented unstalled.
            if (!STALL && zero_instr) begin
               state_d = StHalt;
            end
         end
         StHalt: state_d = StHalt;
         default: state_d = StInit;
      endcase
   end

   assign pc_d = run ? next_pc : pc_q;

   always_comb begin
      retired_d = retired_q;
      if (retire && (retired_q != {CNT_W{1'b1}})) begin
         retired_d = retired_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= StInit;
         pc_q      <= {RESET_PC[PC_W-1:1], 1'b0};
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_lab5_fetch_unit.sv
// Scoreboard bench for lab5_fetch_unit: the driver queues expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_lab5_fetch_unit;

   typedef struct {
      string       nm;
      bit          nz;
      logic [7:0]  ia;
      logic        v;
      logic        h;
      logic [15:0] ret;
      logic [15:0] ins;
   } exp_t;

   logic        clk;
   logic        rst, rst2;
   logic        stall, br_taken, jmp_en;
   logic [5:0]  br_offset;
   logic [7:0]  jmp_addr;
   logic [7:0]  iaddr, iaddr2;
   logic [15:0] iram_q, iram_q2, instr, instr2;
   logic        valid, valid2, halted, halted2;
   logic [15:0] retired;
   logic [1:0]  retired2;

   logic [15:0] mem [128];
   exp_t        expq [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   assign iram_q  = mem[iaddr[7:1]];
   assign iram_q2 = mem[iaddr2[7:1]];

   lab5_fetch_unit dut (
      .CLK         (clk),
      .RESET       (rst),
      .IADDR       (iaddr),
      .IRAM_Q      (iram_q),
      .INSTR       (instr),
      .INSTR_VALID (valid),
      .STALL       (stall),
      .BR_TAKEN    (br_taken),
      .BR_OFFSET   (br_offset),
      .JMP_EN      (jmp_en),
      .JMP_ADDR    (jmp_addr),
      .HALTED      (halted),
      .RETIRED     (retired)
   );

   // Second instance: no zero-word halt and a 2-bit counter to reach saturation.
   lab5_fetch_unit #(
      .HALT_ON_ZERO (1'b0),
      .CNT_W        (2)
   ) dut_nz (
      .CLK         (clk),
      .RESET       (rst2),
      .IADDR       (iaddr2),
      .IRAM_Q      (iram_q2),
      .INSTR       (instr2),
      .INSTR_VALID (valid2),
      .STALL       (stall),
      .BR_TAKEN    (br_taken),
      .BR_OFFSET   (br_offset),
      .JMP_EN      (jmp_en),
      .JMP_ADDR    (jmp_addr),
      .HALTED      (halted2),
      .RETIRED     (retired2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, checked mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.nz) begin
               check({e.nm, " iaddr"},   {8'h00, iaddr2},    {8'h00, e.ia});
               check({e.nm, " valid"},   {15'h0, valid2},    {15'h0, e.v});
               check({e.nm, " halted"},  {15'h0, halted2},   {15'h0, e.h});
               check({e.nm, " retired"}, {14'h0, retired2},  e.ret);
               check({e.nm, " instr"},   instr2,             e.ins);
            end else begin
               check({e.nm, " iaddr"},   {8'h00, iaddr},     {8'h00, e.ia});
               check({e.nm, " valid"},   {15'h0, valid},     {15'h0, e.v});
               check({e.nm, " halted"},  {15'h0, halted},    {15'h0, e.h});
               check({e.nm, " retired"}, retired,            e.ret);
               check({e.nm, " instr"},   instr,              e.ins);
            end
         end
      end
   end

   // Advance one edge and queue what the selected DUT must show after it.
   task automatic cycle(input string nm, input bit nz, input logic [7:0] ia, input logic v,
                        input logic h, input logic [15:0] ret);
      exp_t e;
      @(posedge clk);
      #1;
      e.nm  = nm;
      e.nz  = nz;
      e.ia  = ia;
      e.v   = v;
      e.h   = h;
      e.ret = ret;
      e.ins = v ? mem[ia[7:1]] : 16'h0000;
      expq.push_back(e);
   endtask

   initial begin
      rst = 1'b1; rst2 = 1'b1;
      stall = 1'b0; br_taken = 1'b0; jmp_en = 1'b0;
      br_offset = 6'd0; jmp_addr = 8'h00;
      for (int i = 0; i < 128; i++) mem[i] = (i < 18) ? 16'h1000 + 16'(i) + 16'd1 : 16'h0000;

      // Reset, one INIT cycle, then sequential fetch with a 3-cycle stall at 06.
      cycle("reset", 0, 8'h00, 0, 0, 16'd0);
      cycle("reset2", 0, 8'h00, 0, 0, 16'd0);
      rst = 1'b0;
      cycle("run0", 0, 8'h00, 1, 0, 16'd0);
      for (int i = 1; i <= 17; i++) begin
         cycle("seq", 0, 8'(2 * i), 1, 0, 16'(i));
         if (i == 3) begin
            stall = 1'b1;
            repeat (3) cycle("stall", 0, 8'h06, 1, 0, 16'd3);
            stall = 1'b0;
         end
      end
      cycle("zero_word", 0, 8'h24, 0, 0, 16'd18);
      cycle("halt", 0, 8'h24, 0, 1, 16'd18);
      jmp_en = 1'b1; jmp_addr = 8'h80; br_taken = 1'b1; br_offset = 6'd5;
      repeat (2) cycle("halt_ignore", 0, 8'h24, 0, 1, 16'd18);
      jmp_en = 1'b0; br_taken = 1'b0;

      // Reset out of HALT, then branch/jump/wrap vectors on an all-nonzero RAM.
      rst = 1'b1;
      cycle("rst_halt", 0, 8'h00, 0, 0, 16'd0);
      rst = 1'b0;
      for (int i = 0; i < 128; i++) mem[i] = 16'hA000 | 16'(i);
      cycle("run_b", 0, 8'h00, 1, 0, 16'd0);
      cycle("seq_b", 0, 8'h02, 1, 0, 16'd1);
      cycle("seq_b", 0, 8'h04, 1, 0, 16'd2);
      jmp_en = 1'b1; jmp_addr = 8'h41; br_taken = 1'b1; br_offset = 6'd5;
      cycle("jmp_wins", 0, 8'h40, 1, 0, 16'd3);
      br_taken = 1'b0; jmp_addr = 8'h10;
      cycle("jmp_10", 0, 8'h10, 1, 0, 16'd4);
      jmp_en = 1'b0; br_taken = 1'b1; br_offset = 6'b111110;
      cycle("br_m2", 0, 8'h0E, 1, 0, 16'd5);
      br_taken = 1'b0; jmp_en = 1'b1; jmp_addr = 8'h10;
      cycle("jmp_10b", 0, 8'h10, 1, 0, 16'd6);
      jmp_en = 1'b0; br_taken = 1'b1; br_offset = 6'd31;
      cycle("br_p31", 0, 8'h50, 1, 0, 16'd7);
      br_taken = 1'b0; jmp_en = 1'b1; jmp_addr = 8'hFE;
      cycle("jmp_fe", 0, 8'hFE, 1, 0, 16'd8);
      jmp_en = 1'b0;
      cycle("wrap_seq", 0, 8'h00, 1, 0, 16'd9);
      cycle("seq_c", 0, 8'h02, 1, 0, 16'd10);
      br_taken = 1'b1; br_offset = 6'b111100;
      cycle("br_wrap", 0, 8'hFC, 1, 0, 16'd11);
      br_taken = 1'b0; stall = 1'b1; jmp_en = 1'b1; jmp_addr = 8'h30;
      cycle("stall_drop", 0, 8'hFC, 1, 0, 16'd11);
      jmp_en = 1'b0; rst = 1'b1;
      cycle("rst_stall", 0, 8'h00, 0, 0, 16'd0);
      rst = 1'b0; stall = 1'b0;
      cycle("run_after", 0, 8'h00, 1, 0, 16'd0);

      // HALT_ON_ZERO=0 instance: a zero word retires; 2-bit counter saturates.
      cycle("nz_reset", 1, 8'h00, 0, 0, 16'd0);
      rst2 = 1'b0;
      mem[0] = 16'h0000;
      cycle("nz_zero", 1, 8'h00, 1, 0, 16'd0);
      cycle("nz_seq", 1, 8'h02, 1, 0, 16'd1);
      cycle("nz_seq", 1, 8'h04, 1, 0, 16'd2);
      cycle("nz_seq", 1, 8'h06, 1, 0, 16'd3);
      cycle("nz_sat", 1, 8'h08, 1, 0, 16'd3);
      cycle("nz_sat", 1, 8'h0A, 1, 0, 16'd3);

      for (int k = 0; k < 4 && expq.size() > 0; k++) @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d expectations pending, expected 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lab5_fetch_unit.md
Name: lab5_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction RAM.
- Owns the program counter and drives the RAM byte address; receives the 16-bit instruction word back.
- Passes the instruction, with a valid flag, to decode.
- Computes next PC from sequential, branch and jump requests; detects halt; counts retired instructions.

Parameters:
- PC_W, 8, PC / instruction-RAM byte-address width; bit 0 always 0.
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_ON_ZERO, 1, when 1 an all-zero instruction word halts fetch.
- CNT_W, 16, retired-instruction counter width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous reset, active-high.
- IADDR  output  PC_W  byte address to instruction RAM (equals PC).
- IRAM_Q  input  16  instruction word returned by RAM; combinational from IADDR.
- INSTR  output  16  instruction to decode; IRAM_Q in RUN, 16'h0000 otherwise.
- INSTR_VALID  output  1  high only in RUN with HALT_ON_ZERO=0 or IRAM_Q nonzero.
- STALL  input  1  hold PC and do not retire this cycle.
- BR_TAKEN  input  1  branch taken for current INSTR (from decode/execute).
- BR_OFFSET  input  6  signed word offset, two's complement, for a taken branch.
- JMP_EN  input  1  absolute jump for current INSTR.
- JMP_ADDR  input  PC_W  jump target byte address; bit 0 ignored (forced 0).
- HALTED  output  1  high in HALT state.
- RETIRED  output  CNT_W  count of retired instructions.

Behaviour:
- Reset values:
  - While RESET=1 at a rising edge: state←INIT, PC←RESET_PC, RETIRED←0.
  - Outputs during/after reset: INSTR=0, INSTR_VALID=0, HALTED=0.
  - Reset takes effect from any state, mid-stall or mid-halt included.
- State machine:
  - INIT:
    - Exactly one cycle after RESET deasserts; gives the RAM's reset-time load one settled cycle.
    - PC held; goes to RUN unconditionally.
  - RUN:
    - Normal fetch.
    - Goes to HALT at the edge where INSTR_VALID would be low because IRAM_Q==0 (HALT_ON_ZERO=1) and STALL=0.
    - If STALL=1, halt detection is deferred.
  - HALT:
    - Terminal until RESET.
    - PC frozen, INSTR=0, INSTR_VALID=0, HALTED=1.
    - All request inputs ignored.
- Next-PC in RUN, priority order:
  1. STALL → PC held.
  2. Zero-instruction halt (HALT_ON_ZERO=1) → PC held; branch/jump ignored.
  3. JMP_EN → {JMP_ADDR[PC_W-1:1],1'b0}.
  4. BR_TAKEN → PC + 2 + (sign_extend(BR_OFFSET) << 1).
  5. Otherwise → PC + 2.
- Arithmetic: all next-PC sums are modulo 2^PC_W.
  - PC=8'hFE sequential → 8'h00.
  - Branch wrap is permitted in both directions; no overflow flag.
- Latency:
  - IADDR is the registered PC; zero-cycle combinational path IRAM_Q→INSTR.
  - New PC visible one cycle after the request edge.
  - Request inputs must be combinational from the current INSTR (single-cycle datapath).
- Retire counter:
  - RETIRED increments at each edge where state=RUN, INSTR_VALID=1 and STALL=0.
  - Saturates at all-ones; never wraps.
- Simultaneous events:
  - JMP_EN and BR_TAKEN both high → jump wins.
  - STALL with any request → request dropped. Upstream must re-present it next cycle.
- Outputs are purely functions of registered state plus IRAM_Q; no latches.

Decomposition:
- Shared package/header lab5_defs:
  - State encoding: INIT=2'd0, RUN=2'd1, HALT=2'd2.
  - Instruction field positions: opcode [15:12], rs [11:9], rt [8:6], imm6 [5:0], funct [2:0].
  - HALT_WORD = 16'h0000.
- One natural sub-module: lab5_next_pc, combinational next-PC mux/adder (priority, sign extension, wrap).
  - The FSM, PC register and counter stay in the top.

Test Plan:
- Reset then run, RAM loaded with 18 nonzero words then zeros:
  - INIT for 1 cycle.
  - IADDR steps 00,02,…,22 with INSTR_VALID=1.
  - At IADDR=8'h24 the zero word halts: HALTED=1, PC frozen at 8'h24, RETIRED=18.
- STALL high 3 cycles at PC=8'h06 → IADDR stays 8'h06, RETIRED unchanged; resumes to 8'h08 after STALL drops.
- Branch: PC=8'h10, BR_TAKEN=1, BR_OFFSET=6'b111110 (−2) → next PC=8'h0E. With BR_OFFSET=6'd31 → 8'h50.
- Jump/branch collision: PC=8'h04, JMP_EN=1 with JMP_ADDR=8'h41, BR_TAKEN=1 → next PC=8'h40.
- Wrap: PC=8'hFE sequential → 8'h00. PC=8'h02, BR_OFFSET=−4 → 8'hFC.
- Reset mid-halt and mid-stall: assert RESET for 1 cycle → PC=RESET_PC, RETIRED=0, HALTED=0, INIT then RUN. With HALT_ON_ZERO=0, a zero word retires and PC advances.
